// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU engine for the EX stage; returns {hi,lo}.
// Define MULDIV_EARLY_OUT_EN to let MUL stop once the remaining multiplier is zero.
module ex_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic                  dbz_o,
    output logic [2*DATA_W-1:0]   result_o
);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_W-1:0]     opnd;
    logic [2*DATA_W-1:0]   acc;
    logic                  is_div, neg_res, neg_rem, dbz_r;

    logic                  accept, div_zero, sign1, sign2, last_iter, mul_last, borrow;
    logic [DATA_W-1:0]     mag1, mag2;
    logic [DATA_W:0]       mul_sum, rem_sh;
    logic [DATA_W+1:0]     diff;
    logic [2*DATA_W-1:0]   mul_nxt, div_nxt, prod, fix_res;

    assign accept   = start_i && !annul_i;
    assign div_zero = op_i[1] && (opdata2_i == '0);
    assign sign1    = !op_i[0] && opdata1_i[DATA_W-1];
    assign sign2    = !op_i[0] && opdata2_i[DATA_W-1];
    assign mag1     = sign1 ? -opdata1_i : opdata1_i;
    assign mag2     = sign2 ? -opdata2_i : opdata2_i;

    // Shift-add step: {hi,lo} with the multiplier consumed from lo's LSB
    assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
    assign mul_nxt  = {mul_sum, acc[DATA_W-1:1]};

    // Restoring step: remainder needs one extra bit after the shift
    assign rem_sh   = acc[2*DATA_W-1:DATA_W-1];
    assign diff     = {1'b0, rem_sh} - {2'b00, opnd};
    assign borrow   = diff[DATA_W+1];
    assign div_nxt  = {(borrow ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0]),
                       acc[DATA_W-2:0], !borrow};

    assign last_iter = (cnt == CNT_W'(1));

`ifdef MULDIV_EARLY_OUT_EN
    logic [DATA_W-1:0] mpl;
    assign mul_last = last_iter || (mpl[DATA_W-1:1] == '0);
    // Skipped iterations would only have shifted right; apply them here
    assign prod     = acc >> cnt;
`else
    assign mul_last = last_iter;
    assign prod     = acc;
`endif

    always_comb begin
        fix_res = neg_res ? -prod : prod;
        if (is_div) begin
            fix_res[2*DATA_W-1:DATA_W] = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
            fix_res[DATA_W-1:0]        = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        ready_o   = 1'b0;
        dbz_o     = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = div_zero ? DONE : (op_i[1] ? DIV : MUL);
            MUL: begin
                busy_o = 1'b1;
                if (mul_last) state_nxt = FIX;
            end
            DIV: begin
                busy_o = 1'b1;
                if (last_iter) state_nxt = FIX;
            end
            FIX: begin
                busy_o    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                ready_o = 1'b1;
                dbz_o   = dbz_r;
                if (!start_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (annul_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= '0;
            opnd     <= '0;
            acc      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            dbz_r    <= 1'b0;
            result_o <= '0;
`ifdef MULDIV_EARLY_OUT_EN
            mpl      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt     <= CNT_W'(DATA_W);
                    opnd    <= op_i[1] ? mag2 : mag1;
                    acc     <= {{DATA_W{1'b0}}, (op_i[1] ? mag1 : mag2)};
                    is_div  <= op_i[1];
                    neg_res <= sign1 ^ sign2;
                    neg_rem <= sign1;
                    dbz_r   <= div_zero;
`ifdef MULDIV_EARLY_OUT_EN
                    mpl     <= mag2;
`endif
                    if (div_zero) result_o <= {opdata1_i, {DATA_W{1'b1}}};
                end
                MUL: begin
                    acc <= mul_nxt;
                    cnt <= cnt - CNT_W'(1);
`ifdef MULDIV_EARLY_OUT_EN
                    mpl <= mpl >> 1;
`endif
                end
                DIV: begin
                    acc <= div_nxt;
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: if (!annul_i) result_o <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed scoreboard bench for ex_muldiv (DATA_W=32).
module tb_ex_muldiv;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start_i = 1'b0;
    logic [1:0]      op_i = 2'b00;
    logic [DW-1:0]   opdata1_i = '0;
    logic [DW-1:0]   opdata2_i = '0;
    logic            annul_i = 1'b0;
    logic            busy_o, ready_o, dbz_o;
    logic [2*DW-1:0] result_o;

    typedef struct {
        logic [2*DW-1:0] res;
        logic            dbz;
        int              lat;
    } exp_t;

    exp_t            sb[$];
    int              checks = 0;
    int              failures = 0;
    logic [2*DW-1:0] last_res = '0;

    ex_muldiv #(.DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .annul_i(annul_i),
        .busy_o(busy_o), .ready_o(ready_o), .dbz_o(dbz_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb2 = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        logic [63:0]     r;
        if (op[1] && b == 0) return {a, 32'hFFFF_FFFF};
        case (op)
            2'b00:   r = sa * sb2;
            2'b01:   r = ua * ub;
            2'b10:   r = {32'(sa % sb2), 32'(sa / sb2)};
            default: r = {32'(ua % ub), 32'(ua / ub)};
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] m;
        int          hb;
        if (op[1]) return (b == 0) ? 1 : DW + 2;
        m  = (!op[0] && b[31]) ? -b : b;
        hb = 0;
        for (int i = 0; i < DW; i++) if (m[i]) hb = i;
`ifdef MULDIV_EARLY_OUT_EN
        return hb + 3;
`else
        return (hb >= 0) ? DW + 2 : 0;
`endif
    endfunction

    // Entered just after a rising edge with the DUT idle; leaves it idle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp_res);
        exp_t e;
        int   n;
        e.res = exp_res;
        e.dbz = op[1] && (b == 0);
        e.lat = exp_lat(op, b);
        sb.push_back(e);
        op_i = op; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
        @(posedge clk); #1;
        n = 1;
        op_i = 2'($urandom); opdata1_i = $urandom; opdata2_i = $urandom;
        while (!ready_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb.pop_front();
        check({tag, ".ready"}, 64'(ready_o), 64'd1);
        check({tag, ".latency"}, 64'(n), 64'(e.lat));
        check({tag, ".result"}, result_o, e.res);
        check({tag, ".dbz"}, 64'(dbz_o), 64'(e.dbz));
        @(posedge clk); #1;
        check({tag, ".hold_ready"}, 64'(ready_o), 64'd1);
        check({tag, ".hold_result"}, result_o, e.res);
        start_i = 1'b0;
        @(posedge clk); #1;
        check({tag, ".idle_ready"}, 64'(ready_o), 64'd0);
        check({tag, ".idle_busy"}, 64'(busy_o), 64'd0);
        check({tag, ".idle_result"}, result_o, e.res);
        @(posedge clk); #1;
        check({tag, ".no_reissue"}, 64'({busy_o, ready_o}), 64'd0);
        last_res = e.res;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        #2;
        check("reset.outputs", {busy_o, ready_o, dbz_o}, 64'd0);
        check("reset.result", result_o, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult_neg", 2'b00, -32'sd3, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
`ifdef MULDIV_EARLY_OUT_EN
        run_op("multu_early", 2'b01, 32'd3, 32'd5, 64'h0000_0000_0000_000F);
`endif
        run_op("div_neg", 2'b10, -32'sd7, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
        run_op("div_neg_divisor", 2'b10, 32'd7, -32'sd2, {32'd1, -32'sd3});

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom);
            ra  = $urandom;
            rb  = (i == 5) ? 32'd0 : $urandom_range(32'hFFFF, 1) << $urandom_range(16, 0);
            run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
        end

        // annul in the same cycle as start: nothing accepted
        op_i = 2'b01; opdata1_i = 32'd9; opdata2_i = 32'd9; start_i = 1'b1; annul_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0; annul_i = 1'b0;
        check("annul_start.busy", 64'({busy_o, ready_o}), 64'd0);

        // annul mid-DIV: accept at T, annul during T+10
        op_i = 2'b10; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
        end
        check("annul_div.busy_before", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        check("annul_div.busy_after", 64'(busy_o), 64'd0);
        check("annul_div.ready_after", 64'(ready_o), 64'd0);
        check("annul_div.result", result_o, last_res);
        @(posedge clk); #1;
        check("annul_div.still_idle", 64'({busy_o, ready_o}), 64'd0);
        run_op("after_annul", 2'b11, 32'd1000, 32'd3, {32'd1, 32'd333});

        // asynchronous reset mid-MUL
        op_i = 2'b01; opdata1_i = 32'd12345; opdata2_i = 32'd678; start_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
        end
        check("rst_mid.busy_before", 64'(busy_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_mid.flags", 64'({busy_o, ready_o, dbz_o}), 64'd0);
        check("rst_mid.result", result_o, 64'd0);
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        last_res = '0;
        @(posedge clk); #1;
        run_op("after_rst", 2'b00, -32'sd100, -32'sd100, 64'd10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
